// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared widths and memory-responder state encoding.
// Revision    : 1.0
// ============================================================================
`default_nettype none

package cpu_pkg;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_array.sv
// ============================================================================
// Module      : mem_array
// Description : Register word store, async-cleared, one write / one read port.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_array #(
  parameter int ADDR_W = cpu_pkg::ADDR_W,
  parameter int DATA_W = cpu_pkg::DATA_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  import cpu_pkg::*;

  localparam int c_depth = 2**ADDR_W;

  logic [DATA_W-1:0] r_mem [c_depth];

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < c_depth; i++) r_mem[i] <= '0;
    end else if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  assign rdata = r_mem[raddr];

endmodule

`default_nettype wire

// File: rtl/mem_responder.sv
// ============================================================================
// Module      : mem_responder
// Description : Valid/ready memory responder with programmable wait states.
// Revision    : 1.0
// ============================================================================
`default_nettype none

module mem_responder #(
  parameter int ADDR_W      = cpu_pkg::ADDR_W,
  parameter int DATA_W      = cpu_pkg::DATA_W,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  input  logic              init_we,
  input  logic [ADDR_W-1:0] init_addr,
  input  logic [DATA_W-1:0] init_data
);
  import cpu_pkg::*;

  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

  mem_state_t        r_state;
  mem_state_t        w_next;
  logic [3:0]        r_cnt;
  logic              r_write;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;

  logic              w_accept;
  logic              w_enter_resp;
  logic              w_init_ok;
  logic              w_op_write;
  logic [ADDR_W-1:0] w_op_addr;
  logic [DATA_W-1:0] w_op_wdata;
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_waddr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [DATA_W-1:0] w_mem_rdata;

  assign w_accept  = (r_state == IDLE) && req_valid;
  assign w_init_ok = (r_state == IDLE) && !req_valid && init_we;

  // With zero wait states RESP is entered on the acceptance edge, before the
  // capture registers hold the request, so the live request fields are used.
  assign w_op_write = (r_state == IDLE) ? req_write : r_write;
  assign w_op_addr  = (r_state == IDLE) ? req_addr  : r_addr;
  assign w_op_wdata = (r_state == IDLE) ? req_wdata : r_wdata;

  assign w_mem_we    = (w_enter_resp && w_op_write) || w_init_ok;
  assign w_mem_waddr = w_init_ok ? init_addr : w_op_addr;
  assign w_mem_wdata = w_init_ok ? init_data : w_op_wdata;

  mem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_mem (
    .CLK   (CLK),
    .RST_N (RST_N),
    .we    (w_mem_we),
    .waddr (w_mem_waddr),
    .wdata (w_mem_wdata),
    .raddr (w_op_addr),
    .rdata (w_mem_rdata)
  );

  always_comb begin
    w_next       = r_state;
    req_ready    = 1'b0;
    rsp_valid    = 1'b0;
    w_enter_resp = 1'b0;
    unique case (r_state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (c_wait_load == 4'd0) begin
            w_next       = RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_next = WAIT;
          end
        end
      end
      WAIT: begin
        if (r_cnt == 4'd1) begin
          w_next       = RESP;
          w_enter_resp = 1'b1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_cnt   <= c_wait_load;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_enter_resp) r_rdata <= w_op_write ? w_op_wdata : w_mem_rdata;
    end
  end

  assign rsp_rdata = r_rdata;

endmodule

`default_nettype wire

// File: tb/tb_mem_responder.sv
// Scoreboard bench: instance 1 has one wait state, instance 0 has none.
`timescale 1ns/1ps
`default_nettype none

module tb_mem_responder;

  logic       CLK = 1'b0;
  logic [1:0] rst_n;
  logic [1:0] req_valid, req_ready, req_write, rsp_valid, rsp_ready, init_we;
  logic [3:0] req_addr  [2];
  logic [7:0] req_wdata [2];
  logic [7:0] rsp_rdata [2];
  logic [3:0] init_addr [2];
  logic [7:0] init_data [2];

  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int acc_cyc [2];

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc++;

  mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(1)) dut1 (
    .CLK(CLK), .RST_N(rst_n[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_write(req_write[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .init_we(init_we[1]), .init_addr(init_addr[1]), .init_data(init_data[1])
  );

  mem_responder #(.ADDR_W(4), .DATA_W(8), .WAIT_CYCLES(0)) dut0 (
    .CLK(CLK), .RST_N(rst_n[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_write(req_write[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .init_we(init_we[0]), .init_addr(init_addr[0]), .init_data(init_data[0])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every response handshake is compared against the queued expectation.
  always @(negedge CLK) begin
    logic [7:0] e;
    if (rsp_valid[1] && rsp_ready[1]) begin
      checks++;
      if (exp_q1.size() == 0) begin
        failures++;
        $display("FAIL rsp1_unexpected actual=%0h required=none", rsp_rdata[1]);
      end else begin
        e = exp_q1.pop_front();
        if (rsp_rdata[1] !== e) begin
          failures++;
          $display("FAIL rsp1_data actual=%0h required=%0h", rsp_rdata[1], e);
        end
      end
    end
    if (rsp_valid[0] && rsp_ready[0]) begin
      checks++;
      if (exp_q0.size() == 0) begin
        failures++;
        $display("FAIL rsp0_unexpected actual=%0h required=none", rsp_rdata[0]);
      end else begin
        e = exp_q0.pop_front();
        if (rsp_rdata[0] !== e) begin
          failures++;
          $display("FAIL rsp0_data actual=%0h required=%0h", rsp_rdata[0], e);
        end
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic preload(input int d, input logic [3:0] a, input logic [7:0] v);
    init_we[d] = 1'b1; init_addr[d] = a; init_data[d] = v;
    @(posedge CLK); #1;
    init_we[d] = 1'b0;
  endtask

  // Called and returns at posedge+1. hold>0 keeps rsp_ready low for hold cycles
  // in RESP while a stray request pulse is driven.
  task automatic do_req(input int d, input logic wr, input logic [3:0] a,
                        input logic [7:0] wd, input logic [7:0] e, input int hold,
                        input logic iwe, input logic [3:0] ia, input logic [7:0] idat);
    int n;
    n = 0;
    while (!req_ready[d] && n < 20) begin @(posedge CLK); #1; n++; end
    if (n >= 20) chk("req_ready_timeout", 32'(req_ready[d]), 32'd1);
    req_valid[d] = 1'b1; req_write[d] = wr; req_addr[d] = a; req_wdata[d] = wd;
    init_we[d] = iwe; init_addr[d] = ia; init_data[d] = idat;
    rsp_ready[d] = (hold == 0);
    if (d == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
    @(posedge CLK); #1;
    acc_cyc[d] = cyc;
    req_valid[d] = 1'b0; init_we[d] = 1'b0;
    n = 0;
    do begin @(negedge CLK); n++; end while (!rsp_valid[d] && n < 20);
    chk($sformatf("latency_d%0d", d), 32'(n), 32'(d + 1));
    chk($sformatf("ready_low_in_resp_d%0d", d), 32'(req_ready[d]), 32'd0);
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(posedge CLK); #1;
        if (k == 1) begin
          req_valid[d] = 1'b1; req_write[d] = 1'b1; req_addr[d] = 4'd3; req_wdata[d] = 8'h99;
        end else begin
          req_valid[d] = 1'b0;
        end
        @(negedge CLK);
        chk($sformatf("hold_valid_k%0d", k), 32'(rsp_valid[d]), 32'd1);
        chk($sformatf("hold_data_k%0d", k), 32'(rsp_rdata[d]), 32'(e));
        chk($sformatf("hold_ready_k%0d", k), 32'(req_ready[d]), 32'd0);
      end
      @(posedge CLK); #1;
      req_valid[d] = 1'b0; rsp_ready[d] = 1'b1;
      @(negedge CLK);
    end
    @(posedge CLK); #1;
    chk($sformatf("ready_after_hs_d%0d", d), 32'(req_ready[d]), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0;
    rst_n = 2'b00; req_valid = '0; req_write = '0; rsp_ready = '0; init_we = '0;
    for (int d = 0; d < 2; d++) begin
      req_addr[d] = '0; req_wdata[d] = '0; init_addr[d] = '0; init_data[d] = '0;
    end
    repeat (3) @(posedge CLK);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_req_ready_d%0d", d), 32'(req_ready[d]), 32'd1);
      chk($sformatf("rst_rsp_valid_d%0d", d), 32'(rsp_valid[d]), 32'd0);
      chk($sformatf("rst_rsp_rdata_d%0d", d), 32'(rsp_rdata[d]), 32'd0);
    end
    rst_n = 2'b11;
    @(posedge CLK); #1;

    // One wait state
    preload(1, 4'd3, 8'hA5);
    do_req(1, 1'b0, 4'd3,  8'h00, 8'hA5, 0, 1'b0, 4'd0, 8'h00);
    do_req(1, 1'b1, 4'd15, 8'h3C, 8'h3C, 0, 1'b0, 4'd0, 8'h00);
    do_req(1, 1'b0, 4'd15, 8'h00, 8'h3C, 0, 1'b0, 4'd0, 8'h00);
    do_req(1, 1'b0, 4'd14, 8'h00, 8'h00, 0, 1'b0, 4'd0, 8'h00);
    do_req(1, 1'b0, 4'd3,  8'h00, 8'hA5, 5, 1'b0, 4'd0, 8'h00);
    do_req(1, 1'b0, 4'd3,  8'h00, 8'hA5, 0, 1'b0, 4'd0, 8'h00);
    do_req(1, 1'b0, 4'd5,  8'h00, 8'h00, 0, 1'b1, 4'd5, 8'hFF);
    do_req(1, 1'b0, 4'd5,  8'h00, 8'h00, 0, 1'b0, 4'd0, 8'h00);

    // Reset while a write waits
    req_valid[1] = 1'b1; req_write[1] = 1'b1; req_addr[1] = 4'd2; req_wdata[1] = 8'h77;
    @(posedge CLK); #1;
    req_valid[1] = 1'b0;
    chk("wait_req_ready", 32'(req_ready[1]), 32'd0);
    #2 rst_n[1] = 1'b0;
    #1;
    chk("midrst_req_ready", 32'(req_ready[1]), 32'd1);
    chk("midrst_rsp_valid", 32'(rsp_valid[1]), 32'd0);
    chk("midrst_rsp_rdata", 32'(rsp_rdata[1]), 32'd0);
    @(posedge CLK); #1;
    rst_n[1] = 1'b1;
    @(posedge CLK); #1;
    do_req(1, 1'b0, 4'd2,  8'h00, 8'h00, 0, 1'b0, 4'd0, 8'h00);
    do_req(1, 1'b0, 4'd15, 8'h00, 8'h00, 0, 1'b0, 4'd0, 8'h00);
    do_req(1, 1'b0, 4'd3,  8'h00, 8'h00, 0, 1'b0, 4'd0, 8'h00);

    // Zero wait states
    preload(0, 4'd0, 8'h11);
    preload(0, 4'd1, 8'h22);
    do_req(0, 1'b0, 4'd0, 8'h00, 8'h11, 0, 1'b0, 4'd0, 8'h00);
    t0 = acc_cyc[0];
    do_req(0, 1'b0, 4'd1, 8'h00, 8'h22, 0, 1'b0, 4'd0, 8'h00);
    chk("b2b_spacing", 32'(acc_cyc[0] - t0), 32'd2);
    do_req(0, 1'b1, 4'd7, 8'h5A, 8'h5A, 0, 1'b0, 4'd0, 8'h00);
    do_req(0, 1'b0, 4'd7, 8'h00, 8'h5A, 0, 1'b0, 4'd0, 8'h00);

    repeat (2) @(posedge CLK);
    #1;
    chk("q1_drained", 32'(exp_q1.size()), 32'd0);
    chk("q0_drained", 32'(exp_q0.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the accumulator CPU's fetch and operand accesses. It owns the 16×8 word store and serves one read or write request at a time over a valid/ready request channel and a valid/ready response channel, with a programmable number of wait states. A side preload port lets the bench or boot logic fill the store while the responder is idle.

## Interface
- ADDR_W, 4, address width; store depth is 2**ADDR_W words
- DATA_W, 8, word width
- WAIT_CYCLES, 1, wait states between request acceptance and response (0..15)

- CLK  in  1  clock, all state changes on rising edge
- RST_N  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  responder can accept a request
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  word address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response present
- rsp_ready  in  1  requester takes response
- rsp_rdata  out  DATA_W  read data (read), or the word written (write)
- init_we  in  1  preload write strobe
- init_addr  in  ADDR_W  preload address
- init_data  in  DATA_W  preload data

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1, rsp_valid=0.
  - On req_valid, capture req_write, req_addr and req_wdata into internal registers and load the wait counter with WAIT_CYCLES.
  - Go to RESP if WAIT_CYCLES==0, else go to WAIT.
- WAIT:
  - req_ready=0.
  - Decrement the counter each cycle. On the cycle where the counter is 1, go to RESP.
- Entering RESP (same edge):
  - Read: rsp_rdata ← mem[addr].
  - Write: mem[addr] ← wdata and rsp_rdata ← wdata.
- RESP:
  - rsp_valid=1, req_ready=0.
  - rsp_rdata is held stable until the handshake.
  - On rsp_ready, go to IDLE.
  - No request is accepted in the handshake cycle.
- Preload:
  - init_we writes mem[init_addr] ← init_data only when state==IDLE and req_valid==0.
  - In any other state, or when a request is being accepted, init_we is ignored.
- Request inputs are ignored outside IDLE. The requester must hold req_valid until it sees req_ready, but the responder captures fields only on acceptance.

## Timing
- Reset values (asynchronous, while RST_N=0):
  - state=IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0.
  - Wait counter = 0, captured request registers = 0, every memory word = 0.
- Latency:
  - Request accepted at edge E0; rsp_valid rises after edge E0+WAIT_CYCLES.
  - WAIT_CYCLES=0 gives rsp_valid in the cycle after acceptance.
- Throughput: at most one transaction per WAIT_CYCLES+2 cycles. req_ready reasserts in the cycle after the rsp handshake.
- rsp_ready held low: RESP persists indefinitely and rsp_rdata does not change.
- rsp_ready high before rsp_valid: no effect.
- Write followed by read of the same address: the read returns the new data, because the write commits on the RESP entry edge.
- Address wrap: not applicable. All 2**ADDR_W addresses are valid and no error response exists.
- Reset mid-transaction:
  - Immediate return to IDLE and rsp_valid=0. The in-flight write is lost if the RESP entry edge has not occurred.
  - The memory is cleared.

## Structure
- Shared package cpu_pkg:
  - ADDR_W and DATA_W constants, shared with the cpu and ALU.
  - State enum mem_state_t {IDLE, WAIT, RESP}.
- Sub-module mem_array:
  - 2**ADDR_W × DATA_W register store, asynchronously cleared.
  - One synchronous write port, muxed between the request and the preload.
  - One combinational read port.
- mem_responder contains the FSM, the wait counter and the capture registers.

## Test plan
- Reset, preload mem[3]=0xA5, read addr 3 with WAIT_CYCLES=1 → rsp_valid 2 cycles after acceptance, rsp_rdata=0xA5.
- Write 0x3C to addr 15, then read addr 15 → write response rsp_rdata=0x3C, read response 0x3C; addr 14 still reads 0x00.
- Hold rsp_ready=0 for 5 cycles in RESP → rsp_valid and rsp_rdata stable, req_ready=0; a req_valid pulse during that time is not captured.
- WAIT_CYCLES=0 build, back-to-back reads of addr 0 and 1 → one response every 2 cycles, req_ready low only in the RESP cycle.
- init_we asserted together with req_valid in IDLE (init addr 5=0xFF, read addr 5) → read returns the old value 0x00, and the preload is dropped.
- Assert RST_N=0 during WAIT of a write 0x77 to addr 2 → outputs return to reset values immediately, and after release addr 2 reads 0x00.
